fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 8, program-counter and ROM address width.
REQ-002 Parameter INS_W, default 16, instruction word width.
REQ-003 Parameter RESET_PC, default 0, PC value after reset.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  block enable; when 0, PC, IR, immediate and flags hold.
REQ-007 pc_load  input  1  capture current PC into pc_snap.
REQ-008 pc_inc  input  1  increment PC.
REQ-009 ins_load  input  1  capture rom_data into IR or immediate register.
REQ-010 rom_addr  output  ADDR_W  instruction ROM address, combinationally equal to PC.
REQ-011 rom_data  input  INS_W  instruction ROM read data, combinational from rom_addr.
REQ-012 opcode  output  4  IR[15:12].
REQ-013 op1_addr  output  4  IR[11:8].
REQ-014 op2_addr  output  4  IR[7:4].
REQ-015 imm  output  INS_W  second-word immediate/address register.
REQ-016 pc_snap  output  ADDR_W  PC captured by pc_load.
REQ-017 ins_valid  output  1  one-cycle pulse after a first-word IR load.
REQ-018 imm_valid  output  1  one-cycle pulse after a second-word load.
REQ-019 word2_pend  output  1  high while the second word of a 2-word instruction is awaited.

Function
REQ-020 rom_addr SHALL equal PC every cycle, with no register delay.
REQ-021 With en=1 and pc_inc=1, PC SHALL become PC+1 modulo 2^ADDR_W (all-ones wraps to 0).
REQ-022 With en=1 and pc_load=1, pc_snap SHALL take the pre-increment PC, including when pc_inc is simultaneously 1.
REQ-023 With en=1, ins_load=1 and word2_pend=0, IR SHALL load rom_data, and ins_valid SHALL be 1 in the following cycle only.
REQ-024 A first-word load with rom_data[15:12] = 4'b1100 (MVI) or 4'b1101 (LDA) SHALL set word2_pend to 1.
REQ-025 With en=1, ins_load=1 and word2_pend=1, imm SHALL load rom_data, IR SHALL hold, word2_pend SHALL clear, and imm_valid SHALL be 1 in the following cycle only.
REQ-026 Every other opcode SHALL leave word2_pend at 0.
REQ-027 Simultaneous ins_load, pc_load and pc_inc SHALL all take effect in the same cycle; IR/imm capture the word at the pre-increment PC.
REQ-028 ins_valid and imm_valid SHALL never be 1 in the same cycle.
REQ-029 While en=0, all registers SHALL hold and both valid pulses SHALL be 0; pulses already due from the prior cycle are suppressed.
REQ-030 A first-word load SHALL NOT disturb imm; imm keeps its last value until the next second-word load.
REQ-031 Sequencing FSM: WORD1 (word2_pend=0) -> WORD2 on an MVI/LDA first-word load; WORD2 -> WORD1 on the next ins_load; no other transitions.

Reset
REQ-032 On rst_n=0, asynchronously: PC=RESET_PC, pc_snap=0, IR=0, imm=0, word2_pend=0, ins_valid=0, imm_valid=0, FSM=WORD1.
REQ-033 Reset asserted mid-instruction (WORD2) SHALL abandon the pending second word; after release the next ins_load is a first-word load.
REQ-034 Release of rst_n SHALL take effect at the first posedge clk after deassertion; no update occurs in the release cycle before that edge.

Structure
REQ-035 Shared package SHALL hold opcode constants (OP_ADD=0000 .. OP_XNOR=1010, OP_MOV=1011, OP_MVI=1100, OP_LDA=1101), field bit positions, and the fetch FSM state enum.
REQ-036 The 2-word opcode test SHALL be a package function reused by the control FSM.
REQ-037 One sub-module, pc_counter (PC register, increment, snapshot), is natural; IR, imm and FSM stay in fetch_unit.

Verification
REQ-038 Reset then load/inc cycle: ROM[0]=16'h0120; pulse ins_load+pc_load, then pc_inc -> opcode=0, op1_addr=1, op2_addr=2, ins_valid pulse, pc_snap=0, PC=1.
REQ-039 MVI pair: ROM[1]=16'hC300, ROM[2]=16'hBEEF; load, inc, load, inc -> word2_pend 1 then 0, imm=16'hBEEF, opcode stays C, imm_valid one pulse, PC=3.
REQ-040 Wrap: drive PC to 8'hFF, pc_inc -> rom_addr=8'h00.
REQ-041 Simultaneous pc_load+pc_inc+ins_load at PC=5 -> pc_snap=5, IR=ROM[5], PC=6.
REQ-042 Reset mid-LDA: after loading ROM word 16'hD000, assert rst_n=0 asynchronously between edges -> word2_pend=0 immediately; the next ins_load loads IR, not imm.
REQ-043 en=0 with pc_inc/ins_load held at 1 for 3 cycles -> PC, IR and imm unchanged, no valid pulses.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: opcodes, instruction
// field positions, fetch FSM states and the two-word opcode test.
package fetch_unit_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOT  = 4'b0101;
  localparam logic [3:0] OP_SHL  = 4'b0110;
  localparam logic [3:0] OP_SHR  = 4'b0111;
  localparam logic [3:0] OP_NAND = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1001;
  localparam logic [3:0] OP_XNOR = 4'b1010;
  localparam logic [3:0] OP_MOV  = 4'b1011;
  localparam logic [3:0] OP_MVI  = 4'b1100;
  localparam logic [3:0] OP_LDA  = 4'b1101;

  // Instruction word field positions
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int OP1_MSB = 11;
  localparam int OP1_LSB = 8;
  localparam int OP2_MSB = 7;
  localparam int OP2_LSB = 4;

  typedef enum logic {
    ST_WORD1 = 1'b0,
    ST_WORD2 = 1'b1
  } fetch_state_e;

  // MVI and LDA carry a second word (immediate / address)
  function automatic logic is_two_word(input logic [3:0] op);
    return (op == OP_MVI) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Control, ROM and decode signals of the fetch unit.
// slave: the fetch unit itself; master: whatever sequences and observes it.
interface fetch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int INS_W  = 16
);
  logic              en;
  logic              pc_load;
  logic              pc_inc;
  logic              ins_load;
  logic [ADDR_W-1:0] rom_addr;
  logic [INS_W-1:0]  rom_data;
  logic [3:0]        opcode;
  logic [3:0]        op1_addr;
  logic [3:0]        op2_addr;
  logic [INS_W-1:0]  imm;
  logic [ADDR_W-1:0] pc_snap;
  logic              ins_valid;
  logic              imm_valid;
  logic              word2_pend;

  modport slave (
    input  en, pc_load, pc_inc, ins_load, rom_data,
    output rom_addr, opcode, op1_addr, op2_addr, imm, pc_snap,
           ins_valid, imm_valid, word2_pend
  );

  modport master (
    output en, pc_load, pc_inc, ins_load, rom_data,
    input  rom_addr, opcode, op1_addr, op2_addr, imm, pc_snap,
           ins_valid, imm_valid, word2_pend
  );
endinterface

// File: rtl/fetch_unit_pc_counter.sv
// Program counter with increment (wrapping) and a snapshot register that
// always captures the pre-increment value.
module pc_counter #(
  parameter int ADDR_W   = 8,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic              i_inc,
  input  logic              i_load,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_snap
);

  localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_snap;

  // PC advances and snapshot captures the current PC while enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc   <= PC_RST;
      r_snap <= '0;
    end else if (i_en) begin
      if (i_inc)  r_pc   <= r_pc + 1'b1;
      if (i_load) r_snap <= r_pc;
    end
  end

  assign o_pc   = r_pc;
  assign o_snap = r_snap;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC drives the ROM address directly, first words
// land in IR, second words of MVI/LDA land in the immediate register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int INS_W    = 16,
  parameter int RESET_PC = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.slave  bus
);

  // Only the decoded fields (bits 15:4) are kept; the low nibble is never read
  localparam int IR_LSB = OP2_LSB;
  localparam int IR_W   = OPC_MSB - IR_LSB + 1;

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic              w_ld_ir;
  logic              w_ld_imm;
  logic [3:0]        w_rom_opc;
  logic [IR_W-1:0]   r_ir;
  logic [INS_W-1:0]  r_imm;
  logic              r_ins_vld;
  logic              r_imm_vld;
  logic [ADDR_W-1:0] w_pc;
  logic [ADDR_W-1:0] w_snap;

  pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (bus.en),
    .i_inc  (bus.pc_inc),
    .i_load (bus.pc_load),
    .o_pc   (w_pc),
    .o_snap (w_snap)
  );

  assign w_rom_opc = bus.rom_data[OPC_MSB:OPC_LSB];

  // Next-state and load strobes: an ins_load is steered to IR or imm by state
  always_comb begin
    w_state_nxt = r_state;
    w_ld_ir     = 1'b0;
    w_ld_imm    = 1'b0;
    if (bus.en && bus.ins_load) begin
      case (r_state)
        ST_WORD1: begin
          w_ld_ir = 1'b1;
          if (is_two_word(w_rom_opc)) w_state_nxt = ST_WORD2;
        end
        ST_WORD2: begin
          w_ld_imm    = 1'b1;
          w_state_nxt = ST_WORD1;
        end
        default: w_state_nxt = ST_WORD1;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_WORD1;
    else        r_state <= w_state_nxt;
  end

  // IR/imm capture and one-cycle valid flags (strobes are already gated by en)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir      <= '0;
      r_imm     <= '0;
      r_ins_vld <= 1'b0;
      r_imm_vld <= 1'b0;
    end else begin
      r_ins_vld <= w_ld_ir;
      r_imm_vld <= w_ld_imm;
      if (w_ld_ir)  r_ir  <= bus.rom_data[OPC_MSB:IR_LSB];
      if (w_ld_imm) r_imm <= bus.rom_data;
    end
  end

  assign bus.rom_addr   = w_pc;
  assign bus.pc_snap    = w_snap;
  assign bus.opcode     = r_ir[OPC_MSB-IR_LSB:OPC_LSB-IR_LSB];
  assign bus.op1_addr   = r_ir[OP1_MSB-IR_LSB:OP1_LSB-IR_LSB];
  assign bus.op2_addr   = r_ir[OP2_MSB-IR_LSB:OP2_LSB-IR_LSB];
  assign bus.imm        = r_imm;
  // A pulse falling in a disabled cycle is dropped, not deferred
  assign bus.ins_valid  = r_ins_vld & bus.en;
  assign bus.imm_valid  = r_imm_vld & bus.en;
  assign bus.word2_pend = (r_state == ST_WORD2);

endmodule
